// File: rtl/alu_rr_arbiter_if.sv
// Handshake bundle between the two requesters, the shared ALU and the
// response consumer on one side and the round-robin arbiter on the other.
interface alu_rr_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;
    logic             alu_cf;
    logic             alu_of;
    logic             alu_sf;
    logic             alu_zf;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       rsp_flags;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_out, alu_cf, alu_of, alu_sf, alu_zf,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_data, rsp_flags
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_out, alu_cf, alu_of, alu_sf, alu_zf,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_data, rsp_flags
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// one op in flight at a time: IDLE (grant) -> EXEC (evaluate) -> RESP.
module alu_rr_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input logic              clk,
    input logic              rst,
    alu_rr_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             gnt0;
    logic             gnt1;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] data_q;
    logic [3:0]       flags_q;
    logic             valid_q;
    logic             id_q;

    // Grants only exist in IDLE; on contention the side not served last wins.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    gnt0 = last_grant;
                    gnt1 = !last_grant;
                end else begin
                    gnt0 = bus.req0_valid;
                    gnt1 = bus.req1_valid;
                end
                if (gnt0 || gnt1)
                    state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (bus.rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            data_q     <= '0;
            flags_q    <= '0;
            valid_q    <= 1'b0;
            id_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (gnt0 || gnt1) begin
                last_grant <= gnt1;
                id_q       <= gnt1;
                op_q       <= gnt1 ? bus.req1_op : bus.req0_op;
                a_q        <= gnt1 ? bus.req1_a  : bus.req0_a;
                b_q        <= gnt1 ? bus.req1_b  : bus.req0_b;
            end
            if (state == EXEC) begin
                data_q  <= bus.alu_out;
                flags_q <= {bus.alu_sf, bus.alu_of, bus.alu_zf, bus.alu_cf};
                valid_q <= 1'b1;
            end
            if (state == RESP && bus.rsp_ready)
                valid_q <= 1'b0;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp_valid  = valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_flags  = flags_q;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: vector table for single ops plus
// sequences for round-robin order, response backpressure and mid-op reset.
module tb_alu_rr_arbiter;
    localparam int WIDTH = 16;
    localparam int OPW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_rr_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_rr_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ALU stand-in: op 1 is A+B with carry/overflow, anything else yields 0.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             cf;
    logic             of;
    assign sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    always_comb begin
        alu_res = '0;
        cf      = 1'b0;
        of      = 1'b0;
        if (bus.alu_op == 4'h1) begin
            alu_res = sum[WIDTH-1:0];
            cf      = sum[WIDTH];
            of      = (bus.alu_a[WIDTH-1] == bus.alu_b[WIDTH-1]) &&
                      (sum[WIDTH-1] != bus.alu_a[WIDTH-1]);
        end
    end
    assign bus.alu_out = alu_res;
    assign bus.alu_cf  = cf;
    assign bus.alu_of  = of;
    assign bus.alu_sf  = alu_res[WIDTH-1];
    assign bus.alu_zf  = (alu_res == '0);

    typedef struct {
        logic             id;
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_data;
        logic [3:0]       exp_flags;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic [OPW-1:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (id == 0) begin
            bus.req0_valid = v;
            bus.req0_op    = op;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end else begin
            bus.req1_valid = v;
            bus.req1_op    = op;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end
    endtask

    // Returns 1 ns after a negedge inside the cycle whose ready is high.
    task automatic wait_grant(input string name, output logic g);
        int k;
        k = 0;
        #1;
        while (!(bus.req0_ready || bus.req1_ready) && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({name, " grant seen"}, 32'(k < 20), 32'd1);
        check({name, " one ready"}, 32'(bus.req0_ready && bus.req1_ready), 32'd0);
        g = bus.req1_ready;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic  g;
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        set_req(32'(v.id), 1'b1, v.op, v.a, v.b);
        wait_grant(nm, g);
        check({nm, " winner"}, 32'(g), 32'(v.id));
        @(negedge clk);
        set_req(32'(v.id), 1'b0, '0, '0, '0);
        #1;
        check({nm, " exec rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({nm, " alu_op"}, 32'(bus.alu_op), 32'(v.op));
        check({nm, " alu_a"}, 32'(bus.alu_a), 32'(v.a));
        check({nm, " alu_b"}, 32'(bus.alu_b), 32'(v.b));
        @(negedge clk);
        #1;
        check({nm, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({nm, " rsp_data"}, 32'(bus.rsp_data), 32'(v.exp_data));
        check({nm, " rsp_flags"}, 32'(bus.rsp_flags), 32'(v.exp_flags));
        check({nm, " rsp_id"}, 32'(bus.rsp_id), 32'(v.id));
        @(negedge clk);
        #1;
        check({nm, " rsp drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic g;

        vecs[0] = '{1'b0, 4'h1, 16'h0003, 16'h0004, 16'h0007, 4'b0000};
        vecs[1] = '{1'b1, 4'h1, 16'h7FFF, 16'h0001, 16'h8000, 4'b1100};
        vecs[2] = '{1'b1, 4'h1, 16'hFFFF, 16'h0001, 16'h0000, 4'b0011};
        vecs[3] = '{1'b0, 4'h1, 16'h1234, 16'h1111, 16'h2345, 4'b0000};
        vecs[4] = '{1'b1, 4'h1, 16'h8000, 16'h8000, 16'h0000, 4'b0111};
        vecs[5] = '{1'b0, 4'h2, 16'h0005, 16'h0005, 16'h0000, 4'b0010};

        do_reset();
        #1;
        check("rst alu_op", 32'(bus.alu_op), 32'd0);
        check("rst alu_a", 32'(bus.alu_a), 32'd0);
        check("rst alu_b", 32'(bus.alu_b), 32'd0);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst rsp_flags", 32'(bus.rsp_flags), 32'd0);
        check("rst ready0", 32'(bus.req0_ready), 32'd0);
        check("rst ready1", 32'(bus.req1_ready), 32'd0);

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], i);

        // Both requesters valid continuously: grants alternate starting at 0.
        do_reset();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'h1, 16'h0010, 16'h0001);
        set_req(1, 1'b1, 4'h1, 16'h0100, 16'h0200);
        for (int n = 0; n < 4; n++) begin
            wait_grant($sformatf("rr%0d", n), g);
            check($sformatf("rr%0d order", n), 32'(g), 32'(n % 2));
            @(negedge clk);
            @(negedge clk);
            #1;
            check($sformatf("rr%0d rsp_valid", n), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("rr%0d rsp_id", n), 32'(bus.rsp_id), 32'(n % 2));
            check($sformatf("rr%0d rsp_data", n), 32'(bus.rsp_data),
                  (n % 2 == 0) ? 32'h0011 : 32'h0300);
            @(negedge clk);
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);

        // Response held under backpressure while req1 keeps waiting.
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 4'h1, 16'h0020, 16'h0022);
        set_req(1, 1'b1, 4'h1, 16'h0001, 16'h0001);
        wait_grant("bp", g);
        check("bp winner", 32'(g), 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, '0);
        @(negedge clk);
        #1;
        check("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp%0d valid", c), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp%0d data", c), 32'(bus.rsp_data), 32'h0042);
            check($sformatf("bp%0d id", c), 32'(bus.rsp_id), 32'd0);
            check($sformatf("bp%0d flags", c), 32'(bus.rsp_flags), 32'd0);
            check($sformatf("bp%0d readys", c),
                  32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp released valid", 32'(bus.rsp_valid), 32'd0);
        check("bp idle ready1", 32'(bus.req1_ready), 32'd1);
        set_req(1, 1'b0, '0, '0, '0);

        // Reset during EXEC aborts the op and restores req0 priority.
        do_reset();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'h1, 16'h0009, 16'h0009);
        wait_grant("mid", g);
        check("mid winner", 32'(g), 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, '0);
        #1;
        check("mid exec alu_a", 32'(bus.alu_a), 32'h0009);
        rst = 1'b0;
        #1;
        check("mid rst alu_op", 32'(bus.alu_op), 32'd0);
        check("mid rst alu_a", 32'(bus.alu_a), 32'd0);
        check("mid rst alu_b", 32'(bus.alu_b), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("mid no rsp%0d", c), 32'(bus.rsp_valid), 32'd0);
        end
        set_req(0, 1'b1, 4'h1, 16'h0001, 16'h0001);
        set_req(1, 1'b1, 4'h1, 16'h0002, 16'h0002);
        wait_grant("mid after", g);
        check("mid after winner", 32'(g), 32'd0);
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
